xm_mem_arbiter: RTL and testbench

Shares the single-port unified memory between the multi-cycle CPU controller (instruction fetch and data access port) and a DMA requester. It latches one-cycle CPU access pulses, arbitrates them against level-held DMA requests, and inserts a fixed number of memory wait states. It also performs byte-lane steering and generates the CPU busy signal that holds the controller in its DECODE, MEM_CONFIRM and MEM_WRITEBACK states.

---
 rtl/xm_pkg.sv | 31 +++
 rtl/xm_byte_lane.sv | 29 ++
 rtl/xm_mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_xm_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xm_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Owner, state and byte-enable encodings live here so all files agree.
package xm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] v,
    input logic [3:0] lim
  );
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/xm_byte_lane.sv
// Byte-lane steering between a 16-bit memory word and byte/word ops.
// Purely combinational; lane is the low address bit.
module xm_byte_lane
  import xm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         byte_i,
  input  logic         lane_i,
  input  logic [W-1:0] wdata_i,
  input  logic [W-1:0] rdata_i,
  output logic [1:0]   be_o,
  output logic [W-1:0] wdata_o,
  output logic [W-1:0] rdata_o
);

  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    if (byte_i) begin
      be_o    = lane_i ? BE_HI : BE_LO;
      wdata_o = {(W/8){wdata_i[7:0]}};
      rdata_o = lane_i ? {{(W-8){1'b0}}, rdata_i[15:8]}
                       : {{(W-8){1'b0}}, rdata_i[7:0]};
    end
  end

endmodule

// File: rtl/xm_mem_arbiter.sv
// Arbitrates CPU pulses and level-held DMA requests onto one
// single-port memory with fixed wait states and byte steering.
module xm_mem_arbiter
  import xm_pkg::*;
#(
  parameter int WORD   = 16,
  parameter int WAIT   = 2,
  parameter int STARVE = 4
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            cpuEn_i,
  input  logic            cpuRW_i,
  input  logic            cpuByte_i,
  input  logic [WORD-1:0] cpuAdr_i,
  input  logic [WORD-1:0] cpuWrData_i,
  output logic [WORD-1:0] cpuRdData_o,
  output logic            cpuBusy_o,
  input  logic            dmaReq_i,
  input  logic            dmaRW_i,
  input  logic            dmaByte_i,
  input  logic [WORD-1:0] dmaAdr_i,
  input  logic [WORD-1:0] dmaWrData_i,
  output logic            dmaGnt_o,
  output logic            dmaDone_o,
  output logic [WORD-1:0] dmaRdData_o,
  output logic            memCs_o,
  output logic            memWe_o,
  output logic [1:0]      memBe_o,
  output logic [WORD-1:0] memAdr_o,
  output logic [WORD-1:0] memWrData_o,
  input  logic [WORD-1:0] memRdData_i
);

  localparam logic [3:0] WAIT_C   = 4'(WAIT);
  localparam logic [3:0] STARVE_C = 4'(STARVE);

  state_e          state_q, state_d;
  owner_e          own_q, own_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      streak_q, streak_d;
  logic            cpu_pend_q, cpu_pend_d;

  logic            hold_rw_q, hold_rw_d;
  logic            hold_byte_q, hold_byte_d;
  logic [WORD-1:0] hold_adr_q, hold_adr_d;
  logic [WORD-1:0] hold_wdata_q, hold_wdata_d;

  logic            acc_rw_q, acc_rw_d;
  logic            acc_byte_q, acc_byte_d;
  logic [WORD-1:0] acc_adr_q, acc_adr_d;
  logic [WORD-1:0] acc_wdata_q, acc_wdata_d;

  logic [WORD-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [WORD-1:0] dma_rdata_q, dma_rdata_d;

  logic            cpu_busy;
  logic            cpu_take;
  logic            dma_win;
  logic            in_access;
  logic [1:0]      lane_be;
  logic [WORD-1:0] lane_wdata;
  logic [WORD-1:0] lane_rdata;

  xm_byte_lane #(
    .W (WORD)
  ) u_lane (
    .byte_i  (acc_byte_q),
    .lane_i  (acc_adr_q[0]),
    .wdata_i (acc_wdata_q),
    .rdata_i (memRdData_i),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  assign cpu_busy = cpu_pend_q &
                    !(state_q == DONE && own_q == OWN_CPU);
  assign cpu_take = cpuEn_i & !cpu_busy;
  // A pending DMA only overrides a pending CPU once it has starved.
  assign dma_win  = dmaReq_i &
                    (!cpu_pend_q || streak_q == STARVE_C);

  always_comb begin
    state_d      = state_q;
    own_d        = own_q;
    cnt_d        = cnt_q;
    streak_d     = streak_q;
    cpu_pend_d   = cpu_pend_q;
    hold_rw_d    = hold_rw_q;
    hold_byte_d  = hold_byte_q;
    hold_adr_d   = hold_adr_q;
    hold_wdata_d = hold_wdata_q;
    acc_rw_d     = acc_rw_q;
    acc_byte_d   = acc_byte_q;
    acc_adr_d    = acc_adr_q;
    acc_wdata_d  = acc_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (dma_win) begin
          own_d       = OWN_DMA;
          acc_rw_d    = dmaRW_i;
          acc_byte_d  = dmaByte_i;
          acc_adr_d   = dmaAdr_i;
          acc_wdata_d = dmaWrData_i;
          state_d     = ACCESS;
          cnt_d       = WAIT_C;
          streak_d    = 4'd0;
        end else if (cpu_pend_q) begin
          own_d       = OWN_CPU;
          acc_rw_d    = hold_rw_q;
          acc_byte_d  = hold_byte_q;
          acc_adr_d   = hold_adr_q;
          acc_wdata_d = hold_wdata_q;
          state_d     = ACCESS;
          cnt_d       = WAIT_C;
          streak_d    = dmaReq_i ? sat_inc(streak_q, STARVE_C)
                                 : 4'd0;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (acc_rw_q == RW_READ) begin
            if (own_q == OWN_CPU) cpu_rdata_d = lane_rdata;
            else                  dma_rdata_d = lane_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (own_q == OWN_CPU) cpu_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Capture last so a pulse in the releasing DONE cycle is kept.
    if (cpu_take) begin
      cpu_pend_d   = 1'b1;
      hold_rw_d    = cpuRW_i;
      hold_byte_d  = cpuByte_i;
      hold_adr_d   = cpuAdr_i;
      hold_wdata_d = cpuWrData_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      own_q        <= OWN_CPU;
      cnt_q        <= 4'd0;
      streak_q     <= 4'd0;
      cpu_pend_q   <= 1'b0;
      hold_rw_q    <= RW_READ;
      hold_byte_q  <= 1'b0;
      hold_adr_q   <= '0;
      hold_wdata_q <= '0;
      acc_rw_q     <= RW_READ;
      acc_byte_q   <= 1'b0;
      acc_adr_q    <= '0;
      acc_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      cpu_pend_q   <= cpu_pend_d;
      hold_rw_q    <= hold_rw_d;
      hold_byte_q  <= hold_byte_d;
      hold_adr_q   <= hold_adr_d;
      hold_wdata_q <= hold_wdata_d;
      acc_rw_q     <= acc_rw_d;
      acc_byte_q   <= acc_byte_d;
      acc_adr_q    <= acc_adr_d;
      acc_wdata_q  <= acc_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign in_access   = (state_q == ACCESS);
  assign memCs_o     = in_access;
  assign memWe_o     = in_access & (acc_rw_q == RW_WRITE);
  assign memBe_o     = in_access ? lane_be : BE_NONE;
  assign memAdr_o    = in_access ? {acc_adr_q[WORD-1:1], 1'b0} : '0;
  assign memWrData_o = in_access ? lane_wdata : '0;

  assign cpuBusy_o   = cpu_busy;
  assign cpuRdData_o = cpu_rdata_q;
  assign dmaRdData_o = dma_rdata_q;
  assign dmaGnt_o    = (own_q == OWN_DMA) && (state_q != IDLE);
  assign dmaDone_o   = (own_q == OWN_DMA) && (state_q == DONE);

endmodule

// File: tb/tb_xm_mem_arbiter.sv
// Directed bench for xm_mem_arbiter at WAIT=2, STARVE=4.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_xm_mem_arbiter;

  logic        clk;
  logic        arst;
  logic        cpu_en, cpu_rw, cpu_byte;
  logic [15:0] cpu_adr, cpu_wd, cpu_rd;
  logic        cpu_busy;
  logic        dma_req, dma_rw, dma_byte;
  logic [15:0] dma_adr, dma_wd, dma_rd;
  logic        dma_gnt, dma_done;
  logic        mem_cs, mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_adr, mem_wd, mem_rd;

  int n_cmp = 0;
  int n_err = 0;

  xm_mem_arbiter #(
    .WORD   (16),
    .WAIT   (2),
    .STARVE (4)
  ) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .cpuEn_i     (cpu_en),
    .cpuRW_i     (cpu_rw),
    .cpuByte_i   (cpu_byte),
    .cpuAdr_i    (cpu_adr),
    .cpuWrData_i (cpu_wd),
    .cpuRdData_o (cpu_rd),
    .cpuBusy_o   (cpu_busy),
    .dmaReq_i    (dma_req),
    .dmaRW_i     (dma_rw),
    .dmaByte_i   (dma_byte),
    .dmaAdr_i    (dma_adr),
    .dmaWrData_i (dma_wd),
    .dmaGnt_o    (dma_gnt),
    .dmaDone_o   (dma_done),
    .dmaRdData_o (dma_rd),
    .memCs_o     (mem_cs),
    .memWe_o     (mem_we),
    .memBe_o     (mem_be),
    .memAdr_o    (mem_adr),
    .memWrData_o (mem_wd),
    .memRdData_i (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse cpuEn_i in the current cycle; returns in the following cycle.
  task automatic cpu_go(input logic rw, input logic byt,
                        input logic [15:0] adr,
                        input logic [15:0] wd);
    cpu_en   = 1'b1;
    cpu_rw   = rw;
    cpu_byte = byt;
    cpu_adr  = adr;
    cpu_wd   = wd;
    tick();
    cpu_en   = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    cpu_en = 0; cpu_rw = 0; cpu_byte = 0;
    cpu_adr = '0; cpu_wd = '0;
    dma_req = 0; dma_rw = 0; dma_byte = 0;
    dma_adr = '0; dma_wd = '0;
    mem_rd = '0;
    tick();
    tick();
    chk("rst_cs", 32'(mem_cs), 32'h0);
    chk("rst_busy", 32'(cpu_busy), 32'h0);
    chk("rst_gnt", 32'(dma_gnt), 32'h0);
    chk("rst_be", 32'(mem_be), 32'h0);
    chk("rst_cpurd", 32'(cpu_rd), 32'h0);
    chk("rst_dmard", 32'(dma_rd), 32'h0);
    arst = 1'b0;
    tick();

    // CPU word read, adr 0x0100
    mem_rd = 16'hBEEF;
    cpu_go(1'b0, 1'b0, 16'h0100, 16'h0000);
    chk("wr1_busy_c1", 32'(cpu_busy), 32'h1);
    chk("wr1_cs_c1", 32'(mem_cs), 32'h0);
    tick();
    chk("wr1_cs_c2", 32'(mem_cs), 32'h1);
    chk("wr1_adr_c2", 32'(mem_adr), 32'h0100);
    chk("wr1_be_c2", 32'(mem_be), 32'h3);
    chk("wr1_we_c2", 32'(mem_we), 32'h0);
    tick();
    chk("wr1_cs_c3", 32'(mem_cs), 32'h1);
    tick();
    chk("wr1_cs_c4", 32'(mem_cs), 32'h1);
    chk("wr1_busy_c4", 32'(cpu_busy), 32'h1);
    tick();
    chk("wr1_cs_c5", 32'(mem_cs), 32'h0);
    chk("wr1_busy_c5", 32'(cpu_busy), 32'h0);
    chk("wr1_rd_c5", 32'(cpu_rd), 32'hBEEF);
    tick();

    // CPU byte write, adr 0x0203 data 0x00A5
    cpu_go(1'b1, 1'b1, 16'h0203, 16'h00A5);
    tick();
    chk("bw_adr", 32'(mem_adr), 32'h0202);
    chk("bw_be", 32'(mem_be), 32'h2);
    chk("bw_wd", 32'(mem_wd), 32'hA5A5);
    chk("bw_we", 32'(mem_we), 32'h1);
    tick(); tick(); tick();
    chk("bw_busy_done", 32'(cpu_busy), 32'h0);
    chk("bw_rd_keep", 32'(cpu_rd), 32'hBEEF);
    tick();

    // CPU byte read, adr 0x0011, high lane
    mem_rd = 16'h12F0;
    cpu_go(1'b0, 1'b1, 16'h0011, 16'h0000);
    tick();
    chk("br_be", 32'(mem_be), 32'h2);
    tick(); tick(); tick();
    chk("br_rd", 32'(cpu_rd), 32'h0012);
    tick();

    // DMA byte read, adr 0x0800, low lane
    dma_req = 1'b1; dma_rw = 1'b0; dma_byte = 1'b1;
    dma_adr = 16'h0800;
    tick();
    chk("dma_gnt_c1", 32'(dma_gnt), 32'h1);
    chk("dma_cs_c1", 32'(mem_cs), 32'h1);
    chk("dma_be_c1", 32'(mem_be), 32'h1);
    chk("dma_adr_c1", 32'(mem_adr), 32'h0800);
    tick();
    chk("dma_done_c2", 32'(dma_done), 32'h0);
    tick();
    chk("dma_cs_c3", 32'(mem_cs), 32'h1);
    tick();
    chk("dma_done_c4", 32'(dma_done), 32'h1);
    chk("dma_rd_c4", 32'(dma_rd), 32'h00F0);
    chk("dma_cs_c4", 32'(mem_cs), 32'h0);
    chk("dma_cpurd_keep", 32'(cpu_rd), 32'h0012);
    dma_req = 1'b0;
    tick();
    chk("dma_done_c5", 32'(dma_done), 32'h0);
    chk("dma_gnt_c5", 32'(dma_gnt), 32'h0);

    // Simultaneous CPU pulse and DMA word write
    mem_rd = 16'h5A5A;
    dma_req = 1'b1; dma_rw = 1'b1; dma_byte = 1'b0;
    dma_adr = 16'h0030; dma_wd = 16'h1234;
    cpu_go(1'b0, 1'b0, 16'h0020, 16'h0000);
    chk("sim_gnt_c1", 32'(dma_gnt), 32'h1);
    chk("sim_adr_c1", 32'(mem_adr), 32'h0030);
    chk("sim_wd_c1", 32'(mem_wd), 32'h1234);
    chk("sim_busy_c1", 32'(cpu_busy), 32'h1);
    tick(); tick(); tick();
    chk("sim_done_c4", 32'(dma_done), 32'h1);
    chk("sim_busy_c4", 32'(cpu_busy), 32'h1);
    dma_req = 1'b0;
    tick();
    chk("sim_busy_c5", 32'(cpu_busy), 32'h1);
    tick();
    chk("sim_cpu_adr_c6", 32'(mem_adr), 32'h0020);
    chk("sim_cpu_gnt_c6", 32'(dma_gnt), 32'h0);
    tick(); tick();
    chk("sim_busy_c8", 32'(cpu_busy), 32'h1);
    tick();
    chk("sim_busy_c9", 32'(cpu_busy), 32'h0);
    chk("sim_rd_c9", 32'(cpu_rd), 32'h5A5A);
    tick();

    // Starvation: four CPU grants, then DMA
    dma_rw = 1'b0; dma_byte = 1'b0; dma_adr = 16'h0600;
    cpu_go(1'b0, 1'b0, 16'h0100, 16'h0000);
    dma_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("stv_cpu%0d_gnt", k), 32'(dma_gnt), 32'h0);
      chk($sformatf("stv_cpu%0d_adr", k), 32'(mem_adr), 32'h0100);
      tick(); tick(); tick();
      cpu_go(1'b0, 1'b0, 16'h0100, 16'h0000);
    end
    tick();
    chk("stv_dma_gnt", 32'(dma_gnt), 32'h1);
    chk("stv_dma_adr", 32'(mem_adr), 32'h0600);
    chk("stv_dma_busy", 32'(cpu_busy), 32'h1);
    tick(); tick(); tick();
    chk("stv_dma_done", 32'(dma_done), 32'h1);
    tick();
    tick();
    chk("stv_after_gnt", 32'(dma_gnt), 32'h0);
    chk("stv_after_adr", 32'(mem_adr), 32'h0100);
    dma_req = 1'b0;
    tick(); tick(); tick();
    chk("stv_after_busy", 32'(cpu_busy), 32'h0);
    tick();

    // Reset in cycle 3 of a CPU access
    mem_rd = 16'h7777;
    cpu_go(1'b0, 1'b0, 16'h0700, 16'h0000);
    tick();
    tick();
    chk("rma_cs_c3", 32'(mem_cs), 32'h1);
    arst = 1'b1;
    tick();
    arst = 1'b0;
    chk("rma_cs_c4", 32'(mem_cs), 32'h0);
    chk("rma_busy_c4", 32'(cpu_busy), 32'h0);
    chk("rma_rd_c4", 32'(cpu_rd), 32'h0000);
    tick();
    chk("rma_cs_c5", 32'(mem_cs), 32'h0);
    chk("rma_busy_c5", 32'(cpu_busy), 32'h0);
    cpu_go(1'b0, 1'b0, 16'h0702, 16'h0000);
    chk("rma2_busy_c1", 32'(cpu_busy), 32'h1);
    tick();
    chk("rma2_adr_c2", 32'(mem_adr), 32'h0702);
    tick(); tick(); tick();
    chk("rma2_busy_c5", 32'(cpu_busy), 32'h0);
    chk("rma2_rd_c5", 32'(cpu_rd), 32'h7777);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
